// File: rtl/instr_encode_loader.sv
// Encodes mnemonic-level instruction requests into 32-bit MIPS words, queues them and
// writes them into instruction memory. Optional load/store ops: INSTR_ENC_LOAD_STORE_EN.
`timescale 1ns/1ps
module instr_encode_loader #(
    parameter int unsigned       DEPTH     = 4,
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_op,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_shamt,
    input  logic [15:0]       req_imm,
    input  logic [25:0]       req_target,
    input  logic              req_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ack,
    output logic              done,
    output logic              err_illegal
);

    localparam int unsigned    PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [32:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;

    logic [31:0] enc_word;
    logic        enc_illegal;
    logic [5:0]  funct;
    logic        is_r;
    logic        shift_imm;
    logic        full, push, pop;
    logic [32:0] head;

    always_comb begin
        enc_word    = '0;
        enc_illegal = 1'b0;
        funct       = '0;
        is_r        = 1'b0;
        shift_imm   = 1'b0;
        case (req_op)
            6'd0:  enc_word = '0;
            6'd1:  begin is_r = 1'b1; funct = 6'h20; end
            6'd2:  begin is_r = 1'b1; funct = 6'h21; end
            6'd3:  begin is_r = 1'b1; funct = 6'h22; end
            6'd4:  begin is_r = 1'b1; funct = 6'h23; end
            6'd5:  begin is_r = 1'b1; funct = 6'h24; end
            6'd6:  begin is_r = 1'b1; funct = 6'h25; end
            6'd7:  begin is_r = 1'b1; funct = 6'h26; end
            6'd8:  begin is_r = 1'b1; funct = 6'h27; end
            6'd9:  begin is_r = 1'b1; funct = 6'h00; shift_imm = 1'b1; end
            6'd10: begin is_r = 1'b1; funct = 6'h02; shift_imm = 1'b1; end
            6'd11: begin is_r = 1'b1; funct = 6'h03; shift_imm = 1'b1; end
            6'd12: begin is_r = 1'b1; funct = 6'h04; end
            6'd13: begin is_r = 1'b1; funct = 6'h06; end
            6'd14: begin is_r = 1'b1; funct = 6'h07; end
            6'd15: begin is_r = 1'b1; funct = 6'h2a; end
            6'd16: begin is_r = 1'b1; funct = 6'h2b; end
            6'd17: begin is_r = 1'b1; funct = 6'h08; end
            6'd18: begin is_r = 1'b1; funct = 6'h09; end
            6'd19: enc_word = {6'h08, req_rs, req_rt, req_imm};
            6'd20: enc_word = {6'h09, req_rs, req_rt, req_imm};
            6'd21: enc_word = {6'h0c, req_rs, req_rt, req_imm};
            6'd22: enc_word = {6'h0d, req_rs, req_rt, req_imm};
            6'd23: enc_word = {6'h0e, req_rs, req_rt, req_imm};
            6'd24: enc_word = {6'h0a, req_rs, req_rt, req_imm};
            6'd25: enc_word = {6'h0b, req_rs, req_rt, req_imm};
            6'd26: enc_word = {6'h0f, 5'd0, req_rt, req_imm};
            6'd27: enc_word = {6'h04, req_rs, req_rt, req_imm};
            6'd28: enc_word = {6'h05, req_rs, req_rt, req_imm};
            6'd29: enc_word = {6'h06, req_rs, 5'd0, req_imm};
            6'd30: enc_word = {6'h07, req_rs, 5'd0, req_imm};
            // REGIMM branches are distinguished by the rt field
            6'd31: enc_word = {6'h01, req_rs, 5'd0, req_imm};
            6'd32: enc_word = {6'h01, req_rs, 5'd1, req_imm};
            6'd33: enc_word = {6'h02, req_target};
            6'd34: enc_word = {6'h03, req_target};
`ifdef INSTR_ENC_LOAD_STORE_EN
            6'd35: enc_word = {6'h20, req_rs, req_rt, req_imm};
            6'd36: enc_word = {6'h24, req_rs, req_rt, req_imm};
            6'd37: enc_word = {6'h21, req_rs, req_rt, req_imm};
            6'd38: enc_word = {6'h25, req_rs, req_rt, req_imm};
            6'd39: enc_word = {6'h23, req_rs, req_rt, req_imm};
            6'd40: enc_word = {6'h28, req_rs, req_rt, req_imm};
            6'd41: enc_word = {6'h29, req_rs, req_rt, req_imm};
            6'd42: enc_word = {6'h2b, req_rs, req_rt, req_imm};
`endif
            default: enc_illegal = 1'b1;
        endcase
        if (is_r) begin
            enc_word = {6'h00,
                        shift_imm ? 5'd0 : req_rs,
                        (req_op == 6'd17 || req_op == 6'd18) ? 5'd0 : req_rt,
                        (req_op == 6'd17) ? 5'd0 : req_rd,
                        shift_imm ? req_shamt : 5'd0,
                        funct};
        end
    end

    always_comb begin
        head      = mem_q[rd_ptr_q];
        full      = (count_q == FULL_CNT);
        push      = req_valid && !full;
        pop       = (state_q == ST_WRITE) && imem_ack;
        count_d   = count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
        wr_ptr_d  = wr_ptr_q + PTR_W'(push);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
        err_d     = err_q | (push & enc_illegal);
        state_d   = state_q;
        addr_d    = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                // count_d includes a same-cycle push, so a refill keeps writes back-to-back
                if (pop) begin
                    addr_d = addr_q + ADDR_W'(4);
                    if (head[32])            state_d = ST_DONE;
                    else if (count_d == '0)  state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                addr_d  = BASE_ADDR;
                state_d = (count_q != '0) ? ST_WRITE : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {req_last, enc_word};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_IDLE;
            addr_q   <= BASE_ADDR;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
        end
    end

    assign req_ready   = !full;
    assign imem_we     = (state_q == ST_WRITE);
    assign imem_addr   = addr_q;
    assign imem_wdata  = imem_we ? head[31:0] : '0;
    assign done        = (state_q == ST_DONE);
    assign err_illegal = err_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Bench for instr_encode_loader: directed encodings, back-pressure, done/reset behaviour
// and randomized traffic against a table-driven encoding model with an address/queue model.
`timescale 1ns/1ps
module tb_instr_encode_loader;

    localparam int          DEPTH  = 4;
    localparam int          ADDR_W = 32;
    localparam logic [31:0] BASE   = 32'h0;
`ifdef INSTR_ENC_LOAD_STORE_EN
    localparam bit LS_EN = 1'b1;
`else
    localparam bit LS_EN = 1'b0;
`endif

    // funct codes for ops 0..18, major opcodes for ops 19..42
    localparam int RF[19]  = '{0, 32, 33, 34, 35, 36, 37, 38, 39, 0, 2, 3, 4, 6, 7, 42, 43, 8, 9};
    localparam int IOP[24] = '{8, 9, 12, 13, 14, 10, 11, 15, 4, 5, 6, 7, 1, 1, 2, 3,
                               32, 36, 33, 37, 35, 40, 41, 43};

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_last;
    logic [5:0]  req_op;
    logic [4:0]  req_rs, req_rt, req_rd, req_shamt;
    logic [15:0] req_imm;
    logic [25:0] req_target;
    logic        imem_we, imem_ack, done, err_illegal;
    logic [31:0] imem_addr, imem_wdata;

    instr_encode_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_shamt(req_shamt), .req_imm(req_imm), .req_target(req_target),
        .req_last(req_last), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_ack(imem_ack), .done(done),
        .err_illegal(err_illegal)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t         obs[$];
    wr_t         expq[$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          vecs = 0;
    int          errs = 0;
    logic [31:0] exp_addr = BASE;
    int          exp_done = 0;
    bit          exp_err = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        cyc++;
        if (rst_n && imem_we && imem_ack) obs.push_back('{imem_addr, imem_wdata, cyc});
        if (rst_n && done) done_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] ref_word(input int op, input logic [4:0] rs_i, rt_i, rd_i, sh_i,
                                             input logic [15:0] imm, input logic [25:0] tgt,
                                             output bit ill);
        logic [4:0] rs, rt, rd, sh;
        logic [5:0] code;
        rs = rs_i; rt = rt_i; rd = rd_i; sh = sh_i;
        ill = 1'b0;
        if (op == 0) return '0;
        if (op <= 18) begin
            code = 6'(RF[op]);
            if (op >= 9 && op <= 11) rs = '0; else sh = '0;
            if (op == 17 || op == 18) rt = '0;
            if (op == 17) rd = '0;
            return {6'h00, rs, rt, rd, sh, code};
        end
        if (op > 42 || (op >= 35 && !LS_EN)) begin
            ill = 1'b1;
            return '0;
        end
        code = 6'(IOP[op - 19]);
        if (op == 33 || op == 34) return {code, tgt};
        if (op == 26) rs = '0;
        if (op >= 29 && op <= 31) rt = '0;
        if (op == 32) rt = 5'd1;
        return {code, rs, rt, imm};
    endfunction

    task automatic drive_req(input int op, input int rs, input int rt, input int rd, input int sh,
                             input int imm, input int tgt, input bit last);
        bit  ill;
        wr_t e;
        req_op = 6'(op); req_rs = 5'(rs); req_rt = 5'(rt); req_rd = 5'(rd);
        req_shamt = 5'(sh); req_imm = 16'(imm); req_target = 26'(tgt);
        req_last = last; req_valid = 1'b1;
        e.data = ref_word(op, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 16'(imm), 26'(tgt), ill);
        e.addr = exp_addr;
        e.cyc  = 0;
        expq.push_back(e);
        if (ill) exp_err = 1'b1;
        if (last) begin
            exp_addr = BASE;
            exp_done++;
        end else begin
            exp_addr = exp_addr + 32'd4;
        end
    endtask

    task automatic drive_rand(input bit last, input bit allow_ill);
        int op;
        if (allow_ill && ($urandom % 5 == 0)) op = $urandom_range(63, 43);
        else                                  op = $urandom_range(42, 0);
        drive_req(op, $urandom % 32, $urandom % 32, $urandom % 32, $urandom % 32,
                  $urandom % 65536, $urandom % (1 << 26), last);
    endtask

    task automatic wait_accept();
        bit acc = 1'b0;
        for (int k = 0; k < 300 && !acc; k++) begin
            @(negedge clk);
            if (req_ready) acc = 1'b1;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        vecs++;
        if (!acc) begin
            errs++;
            $display("FAIL accept_timeout: req_ready=%b, required 1 within 300 cycles", req_ready);
        end
    endtask

    task automatic send(input int op, input int rs, input int rt, input int rd, input int sh,
                        input int imm, input int tgt, input bit last);
        drive_req(op, rs, rt, rd, sh, imm, tgt, last);
        wait_accept();
    endtask

    task automatic wait_drain(input int n);
        bit ok = 1'b0;
        for (int k = 0; k < 1000 && !ok; k++) begin
            @(negedge clk);
            if (obs.size() >= n) ok = 1'b1;
        end
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        vecs++;
        if (!ok || obs.size() != n) begin
            errs++;
            $display("FAIL drain_count: got %0d writes, required %0d", obs.size(), n);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_rs = '0; req_rt = '0; req_rd = '0;
        req_shamt = '0; req_imm = '0; req_target = '0; req_last = 1'b0; imem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_addr = BASE; exp_err = 1'b0;
        obs.delete(); expq.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        vecs += 6;
        if (req_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b, required 1", req_ready); end
        if (imem_we !== 1'b0) begin errs++; $display("FAIL reset_we: got %b, required 0", imem_we); end
        if (imem_addr !== BASE) begin errs++; $display("FAIL reset_addr: got %h, required %h", imem_addr, BASE); end
        if (imem_wdata !== 32'h0) begin errs++; $display("FAIL reset_wdata: got %h, required 0", imem_wdata); end
        if (done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b, required 0", done); end
        if (err_illegal !== 1'b0) begin errs++; $display("FAIL reset_err: got %b, required 0", err_illegal); end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] want[8] = '{32'h00221820, 32'h2008FFFF, 32'h3C011234, 32'h04810003,
                                 32'h04800003, 32'h00021900, 32'h03E00008, 32'h08100000};
        obs.delete(); expq.delete();
        imem_ack = 1'b1;
        send(1, 1, 2, 3, 0, 0, 0, 1'b0);
        send(19, 0, 8, 0, 0, 16'hFFFF, 0, 1'b0);
        send(26, 7, 1, 0, 0, 16'h1234, 0, 1'b0);
        send(32, 4, 9, 0, 0, 3, 0, 1'b0);
        send(31, 4, 9, 0, 0, 3, 0, 1'b0);
        send(9, 5, 2, 3, 4, 0, 0, 1'b0);
        send(17, 31, 5, 6, 0, 0, 0, 1'b0);
        send(33, 0, 0, 0, 0, 0, 26'h0100000, 1'b1);
        wait_drain(8);
        for (int i = 0; i < 8; i++) begin
            logic [31:0] ga = '0, gd = '0;
            if (i < obs.size()) begin ga = obs[i].addr; gd = obs[i].data; end
            vecs++;
            if (gd !== want[i] || ga !== BASE + 32'(4 * i)) begin
                errs++;
                $display("FAIL directed_word[%0d]: got addr=%h data=%h, required addr=%h data=%h",
                         i, ga, gd, BASE + 32'(4 * i), want[i]);
            end
        end
    endtask

    task automatic test_full();
        obs.delete(); expq.delete();
        imem_ack = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive_rand(1'b0, 1'b0);
            wait_accept();
        end
        @(negedge clk);
        vecs++;
        if (req_ready !== 1'b0) begin errs++; $display("FAIL full_ready: got %b, required 0", req_ready); end
        @(posedge clk); #1;
        drive_rand(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vecs += 4;
            if (req_ready !== 1'b0) begin errs++; $display("FAIL full_hold_ready: got %b, required 0", req_ready); end
            if (imem_we !== 1'b1) begin errs++; $display("FAIL full_hold_we: got %b, required 1", imem_we); end
            if (imem_addr !== expq[0].addr) begin errs++; $display("FAIL full_hold_addr: got %h, required %h", imem_addr, expq[0].addr); end
            if (imem_wdata !== expq[0].data) begin errs++; $display("FAIL full_hold_wdata: got %h, required %h", imem_wdata, expq[0].data); end
        end
        @(posedge clk); #1;
        imem_ack = 1'b1;
        wait_accept();
        wait_drain(DEPTH + 1);
        for (int i = 0; i < DEPTH + 1; i++) begin
            logic [31:0] ga = '0, gd = '0;
            int gc = 0;
            if (i < obs.size()) begin ga = obs[i].addr; gd = obs[i].data; gc = obs[i].cyc - obs[0].cyc; end
            vecs++;
            if (ga !== expq[i].addr || gd !== expq[i].data || gc != i) begin
                errs++;
                $display("FAIL full_write[%0d]: got addr=%h data=%h slot=%0d, required addr=%h data=%h slot=%0d",
                         i, ga, gd, gc, expq[i].addr, expq[i].data, i);
            end
        end
    endtask

    task automatic test_done();
        int  d0 = done_cnt;
        bit  seen = 1'b0;
        obs.delete(); expq.delete();
        imem_ack = 1'b1;
        drive_rand(1'b0, 1'b0); wait_accept();
        drive_rand(1'b0, 1'b0); wait_accept();
        drive_rand(1'b1, 1'b0); wait_accept();
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        @(negedge clk);
        vecs += 3;
        if (!seen) begin errs++; $display("FAIL done_pulse: got no pulse, required one"); end
        if (done !== 1'b0) begin errs++; $display("FAIL done_width: got done=%b a cycle later, required 0", done); end
        if (imem_addr !== BASE) begin errs++; $display("FAIL done_addr: got %h, required %h", imem_addr, BASE); end
        wait_drain(3);
        vecs++;
        if (done_cnt - d0 != 1) begin errs++; $display("FAIL done_count: got %0d pulses, required 1", done_cnt - d0); end
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if (obs[i].addr !== expq[i].addr || obs[i].data !== expq[i].data) begin
                errs++;
                $display("FAIL done_write[%0d]: got addr=%h data=%h, required addr=%h data=%h",
                         i, obs[i].addr, obs[i].data, expq[i].addr, expq[i].data);
            end
        end
    endtask

    task automatic test_random();
        int d0 = done_cnt;
        int e0 = exp_done;
        bit busy = 1'b1;
        obs.delete(); expq.delete();
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if ($urandom % 4 == 0) begin @(posedge clk); #1; end
                    drive_rand((i == 39) || ($urandom % 6 == 0), 1'b1);
                    wait_accept();
                end
                busy = 1'b0;
            end
            begin
                while (busy) begin
                    @(posedge clk); #1;
                    imem_ack = 1'($urandom % 2);
                end
            end
        join
        imem_ack = 1'b1;
        wait_drain(40);
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ga = '0, gd = '0;
            if (i < obs.size()) begin ga = obs[i].addr; gd = obs[i].data; end
            vecs++;
            if (ga !== expq[i].addr || gd !== expq[i].data) begin
                errs++;
                $display("FAIL rand_write[%0d]: got addr=%h data=%h, required addr=%h data=%h",
                         i, ga, gd, expq[i].addr, expq[i].data);
            end
        end
        vecs += 2;
        if (done_cnt - d0 != exp_done - e0) begin
            errs++;
            $display("FAIL rand_done_count: got %0d, required %0d", done_cnt - d0, exp_done - e0);
        end
        if (err_illegal !== exp_err) begin
            errs++;
            $display("FAIL rand_err: got %b, required %b", err_illegal, exp_err);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] lw_word = LS_EN ? 32'h8FA80004 : 32'h0;
        obs.delete(); expq.delete();
        imem_ack = 1'b1;
        send(63, 3, 4, 5, 6, 16'hBEEF, 0, 1'b0);
        send(39, 29, 8, 0, 0, 4, 0, 1'b1);
        wait_drain(2);
        vecs += 3;
        if (obs[0].data !== 32'h0) begin errs++; $display("FAIL illegal_word: got %h, required 0", obs[0].data); end
        if (obs[1].data !== lw_word) begin errs++; $display("FAIL lw_word: got %h, required %h", obs[1].data, lw_word); end
        if (err_illegal !== 1'b1) begin errs++; $display("FAIL illegal_err: got %b, required 1", err_illegal); end
        repeat (5) @(negedge clk);
        vecs++;
        if (err_illegal !== 1'b1) begin errs++; $display("FAIL illegal_sticky: got %b, required 1", err_illegal); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int  d0;
        bit  seen = 1'b0;
        obs.delete(); expq.delete();
        imem_ack = 1'b0;
        send(1, 1, 2, 3, 0, 0, 0, 1'b0);
        send(2, 4, 5, 6, 0, 0, 0, 1'b0);
        @(negedge clk);
        vecs++;
        if (imem_we !== 1'b1) begin errs++; $display("FAIL mid_we_before: got %b, required 1", imem_we); end
        for (int k = 0; k < 10 && !seen; k++) begin
            if (imem_we) seen = 1'b1; else @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vecs += 4;
        if (imem_we !== 1'b0) begin errs++; $display("FAIL mid_reset_we: got %b, required 0", imem_we); end
        if (imem_addr !== BASE) begin errs++; $display("FAIL mid_reset_addr: got %h, required %h", imem_addr, BASE); end
        if (req_ready !== 1'b1) begin errs++; $display("FAIL mid_reset_ready: got %b, required 1", req_ready); end
        if (err_illegal !== 1'b0) begin errs++; $display("FAIL mid_reset_err: got %b, required 0", err_illegal); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_addr = BASE; exp_err = 1'b0;
        obs.delete(); expq.delete();
        d0 = done_cnt;
        imem_ack = 1'b1;
        repeat (6) @(negedge clk);
        vecs += 2;
        if (obs.size() != 0) begin errs++; $display("FAIL mid_reset_flush: got %0d writes, required 0", obs.size()); end
        if (done_cnt != d0) begin errs++; $display("FAIL mid_reset_done: got %0d pulses, required 0", done_cnt - d0); end
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        obs.delete(); expq.delete();
        imem_ack = 1'b1;
        send(6, 7, 8, 9, 0, 0, 0, 1'b1);
        @(negedge clk);
        vecs++;
        if (imem_we !== 1'b0) begin errs++; $display("FAIL latency_early: got we=%b one cycle after push, required 0", imem_we); end
        @(negedge clk);
        vecs++;
        if (imem_we !== 1'b1 || imem_wdata !== expq[0].data) begin
            errs++;
            $display("FAIL latency_write: got we=%b data=%h, required we=1 data=%h", imem_we, imem_wdata, expq[0].data);
        end
        wait_drain(1);
    endtask

    initial begin
        do_reset();
        test_reset();
        test_directed();
        test_full();
        test_done();
        test_latency();
        test_random();
        test_illegal();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
